// File: rtl/apb_fanout_pkg.sv
// apb_fanout_pkg: state type, APB response codes and default abort data for the APB fanout.
package apb_fanout_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, ABORT, DECERR} state_t;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;
   localparam logic [1:0]  RESP_DECERR = 2'b11;
   localparam logic [31:0] ERRDATA_DEF = 32'hDEAD_BEEF;
endpackage

// File: rtl/apb_tmo_counter.sv
// apb_tmo_counter: per-transfer wait counter with terminal-count hit, plus saturating timeout tally.
module apb_tmo_counter #(
   parameter int TMO = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_clr,
   input  logic       i_en,
   input  logic       i_tmo,
   output logic       o_hit,
   output logic [7:0] o_tmo_count
);
   logic [7:0] r_wcnt;
   logic [7:0] r_tmo_count;
   always_ff @(posedge clk)
      if (rst) begin
         r_wcnt      <= '0;
         r_tmo_count <= '0;
      end else begin
         r_wcnt      <= i_clr ? '0 : i_en ? r_wcnt + 8'd1 : r_wcnt;
         r_tmo_count <= (i_tmo && r_tmo_count != 8'hFF) ? r_tmo_count + 8'd1 : r_tmo_count;
      end
   assign o_hit       = r_wcnt == 8'(TMO - 1);
   assign o_tmo_count = r_tmo_count;
endmodule

// File: rtl/apb_fanout_tmo.sv
// apb_fanout_tmo: decodes one APB master onto NSLV slaves and aborts
// transfers that wait TMO cycles with SLVERR so the upstream bridge never hangs.
module apb_fanout_tmo
   import apb_fanout_pkg::*;
#(
   parameter int               AWID    = 32,
   parameter int               PDWID   = 32,
   parameter int               NSLV    = 4,
   parameter int               SEL_LO  = 12,
   parameter int               TMO     = 255,
   parameter logic [PDWID-1:0] ERRDATA = PDWID'(ERRDATA_DEF)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_psel,
   input  logic                  s_penable,
   input  logic                  s_pwrite,
   input  logic [AWID-1:0]       s_paddr,
   input  logic [PDWID-1:0]      s_pwdata,
   input  logic [PDWID/8-1:0]    s_pstrb,
   output logic                  s_pready,
   output logic [1:0]            s_presp,
   output logic [PDWID-1:0]      s_prdata,
   output logic [NSLV-1:0]       m_psel,
   output logic                  m_penable,
   output logic                  m_pwrite,
   output logic [AWID-1:0]       m_paddr,
   output logic [PDWID-1:0]      m_pwdata,
   output logic [PDWID/8-1:0]    m_pstrb,
   input  logic [NSLV-1:0]       m_pready,
   input  logic [2*NSLV-1:0]     m_presp,
   input  logic [PDWID*NSLV-1:0] m_prdata,
   output logic                  tmo_pulse,
   output logic [7:0]            tmo_count
);
   localparam int SELW = $clog2(NSLV);
   state_t           r_state;
   logic [SELW-1:0]  r_cur_sel;
   logic [SELW-1:0]  w_idx;
   logic             w_setup;
   logic             w_idx_ok;
   logic             w_rdy;
   logic             w_hit;
   logic             w_wait;
   logic [1:0]       w_resp  [NSLV];
   logic [PDWID-1:0] w_rdata [NSLV];
   for (genvar i = 0; i < NSLV; i++) begin : g_unpack
      assign w_resp[i]  = m_presp[2*i +: 2];
      assign w_rdata[i] = m_prdata[PDWID*i +: PDWID];
   end
   assign w_idx    = s_paddr[SEL_LO +: SELW];
   assign w_idx_ok = int'(w_idx) < NSLV;
   assign w_setup  = r_state == IDLE && s_psel && !s_penable;
   assign w_rdy    = m_pready[r_cur_sel];
   assign w_wait   = r_state == ACCESS && s_psel && !w_rdy;
   // Selects are gated by rst so a reset mid-transfer releases the slave immediately.
   always_comb begin
      m_psel = '0;
      if (!rst && r_state == ACCESS) m_psel[r_cur_sel] = 1'b1;
      else if (!rst && w_setup && w_idx_ok) m_psel[w_idx] = 1'b1;
   end
   assign m_penable = !rst && r_state == ACCESS && s_penable;
   assign m_pwrite  = s_pwrite;
   assign m_paddr   = s_paddr;
   assign m_pwdata  = s_pwdata;
   assign m_pstrb   = s_pstrb;
   assign s_pready  = r_state == ACCESS ? w_rdy : 1'b1;
   assign s_presp   = r_state == ACCESS ? w_resp[r_cur_sel] :
                      r_state == ABORT  ? RESP_SLVERR :
                      r_state == DECERR ? RESP_DECERR : RESP_OKAY;
   assign s_prdata  = r_state == ACCESS ? w_rdata[r_cur_sel] :
                      r_state == ABORT  ? ERRDATA : '0;
   assign tmo_pulse = r_state == ABORT;
   always_ff @(posedge clk)
      if (rst) begin
         r_state   <= IDLE;
         r_cur_sel <= '0;
      end else
         case (r_state)
            IDLE:
               if (w_setup) begin
                  r_state <= w_idx_ok ? ACCESS : DECERR;
                  if (w_idx_ok) r_cur_sel <= w_idx;
               end
            ACCESS:
               if (!s_psel || (s_penable && w_rdy)) r_state <= IDLE;
               else if (!w_rdy && w_hit) r_state <= ABORT;
            default: r_state <= IDLE;
         endcase
   apb_tmo_counter #(.TMO(TMO)) u_cnt (
      .clk         (clk),
      .rst         (rst),
      .i_clr       (w_setup),
      .i_en        (w_wait),
      .i_tmo       (tmo_pulse),
      .o_hit       (w_hit),
      .o_tmo_count (tmo_count)
   );
endmodule

// File: tb/tb_apb_fanout_tmo.sv
// tb_apb_fanout_tmo: scenario tasks with a response scoreboard; a second NSLV=3 instance covers decode errors.
module tb_apb_fanout_tmo;
   typedef struct packed {logic [1:0] rsp; logic [31:0] data;} exp_t;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst, psel, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic [3:0] pstrb;
   logic pready, m_penable, m_pwrite, tmo_pulse;
   logic [1:0] presp;
   logic [31:0] prdata, m_paddr, m_pwdata;
   logic [3:0] m_psel, m_pstrb, m_pready;
   logic [7:0] m_presp, tmo_count;
   logic [127:0] m_prdata;
   logic pready3, m_penable3, m_pwrite3, tmo_pulse3;
   logic [1:0] presp3;
   logic [31:0] prdata3, m_paddr3, m_pwdata3;
   logic [2:0] m_psel3, m_pready3;
   logic [3:0] m_pstrb3;
   logic [5:0] m_presp3;
   logic [95:0] m_prdata3;
   logic [7:0] tmo_count3;
   int n_chk = 0;
   int n_fail = 0;
   exp_t sb[$];
   apb_fanout_tmo u_dut (
      .clk(clk), .rst(rst), .s_psel(psel), .s_penable(penable), .s_pwrite(pwrite),
      .s_paddr(paddr), .s_pwdata(pwdata), .s_pstrb(pstrb), .s_pready(pready),
      .s_presp(presp), .s_prdata(prdata), .m_psel(m_psel), .m_penable(m_penable),
      .m_pwrite(m_pwrite), .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb),
      .m_pready(m_pready), .m_presp(m_presp), .m_prdata(m_prdata),
      .tmo_pulse(tmo_pulse), .tmo_count(tmo_count)
   );
   apb_fanout_tmo #(.NSLV(3)) u_dut3 (
      .clk(clk), .rst(rst), .s_psel(psel), .s_penable(penable), .s_pwrite(pwrite),
      .s_paddr(paddr), .s_pwdata(pwdata), .s_pstrb(pstrb), .s_pready(pready3),
      .s_presp(presp3), .s_prdata(prdata3), .m_psel(m_psel3), .m_penable(m_penable3),
      .m_pwrite(m_pwrite3), .m_paddr(m_paddr3), .m_pwdata(m_pwdata3), .m_pstrb(m_pstrb3),
      .m_pready(m_pready3), .m_presp(m_presp3), .m_prdata(m_prdata3),
      .tmo_pulse(tmo_pulse3), .tmo_count(tmo_count3)
   );
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic sample();
      #2;
   endtask
   task automatic slv(input int i, input logic rdy, input logic [1:0] rsp, input logic [31:0] d);
      m_pready[i] = rdy;
      m_presp[2*i +: 2] = rsp;
      m_prdata[32*i +: 32] = d;
   endtask
   task automatic push_exp(input logic [1:0] rsp, input logic [31:0] d);
      exp_t e;
      e.rsp = rsp;
      e.data = d;
      sb.push_back(e);
   endtask
   task automatic test_reset();
      rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0;
      m_pready = '0; m_presp = '0; m_prdata = '0;
      m_pready3 = '1; m_presp3 = '0; m_prdata3 = {3{32'h7777_7777}};
      cyc(); cyc(); sample();
      n_chk++;
      if ({m_psel, m_penable, pready, presp, prdata, tmo_pulse} !== {4'b0, 1'b0, 1'b1, 2'b0, 32'h0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_outputs: got psel=%b pen=%b rdy=%b resp=%b rdata=%h pulse=%b", m_psel, m_penable, pready, presp, prdata, tmo_pulse);
      end
      rst = 1'b0;
      cyc(); sample();
      n_chk++;
      if ({m_psel, pready, presp, prdata, tmo_count} !== {4'b0, 1'b1, 2'b0, 32'h0, 8'h0}) begin
         n_fail++;
         $display("FAIL reset_idle: got psel=%b rdy=%b resp=%b rdata=%h cnt=%0d", m_psel, pready, presp, prdata, tmo_count);
      end
   endtask
   task automatic test_read();
      exp_t e;
      logic done;
      int w;
      done = 1'b0;
      w = -1;
      cyc();
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0000_2004;
      m_pready = '0;
      slv(0, 1'b0, 2'b11, 32'hFFFF_FFFF);
      slv(2, 1'b0, 2'b00, 32'h1234_5678);
      push_exp(2'b00, 32'h1234_5678);
      sample();
      n_chk++;
      if (m_psel !== 4'b0100 || pready !== 1'b1) begin
         n_fail++;
         $display("FAIL rd_setup: got psel=%b rdy=%b want 0100/1", m_psel, pready);
      end
      cyc();
      penable = 1'b1;
      for (int i = 0; i < 10 && !done; i++) begin
         if (i == 3) m_pready[2] = 1'b1;
         sample();
         n_chk++;
         if (m_psel !== 4'b0100 || m_penable !== 1'b1 || presp !== 2'b00) begin
            n_fail++;
            $display("FAIL rd_access: cycle %0d got psel=%b pen=%b resp=%b", i, m_psel, m_penable, presp);
         end
         if (pready === 1'b1) begin
            done = 1'b1;
            w = i;
            e = sb.pop_front();
            n_chk++;
            if ({presp, prdata} !== {e.rsp, e.data}) begin
               n_fail++;
               $display("FAIL rd_data: got %b/%h want %b/%h", presp, prdata, e.rsp, e.data);
            end
         end else cyc();
      end
      n_chk++;
      if (w != 3) begin
         n_fail++;
         $display("FAIL rd_waits: got %0d wait cycles want 3", w);
      end
      cyc();
      psel = 1'b0; penable = 1'b0; m_pready = '0;
      sample();
      n_chk++;
      if (m_psel !== 4'b0 || pready !== 1'b1 || presp !== 2'b00) begin
         n_fail++;
         $display("FAIL rd_idle: got psel=%b rdy=%b resp=%b", m_psel, pready, presp);
      end
   endtask
   task automatic test_write();
      exp_t e;
      cyc();
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0000_1000;
      pwdata = 32'hA5A5_A5A5; pstrb = 4'hF;
      m_pready = '0;
      slv(1, 1'b1, 2'b00, 32'h0);
      push_exp(2'b00, 32'h0);
      sample();
      n_chk++;
      if ({m_psel, m_pwrite, m_paddr, m_pwdata, m_pstrb} !== {4'b0010, 1'b1, 32'h0000_1000, 32'hA5A5_A5A5, 4'hF}) begin
         n_fail++;
         $display("FAIL wr_setup: got psel=%b w=%b a=%h d=%h s=%h", m_psel, m_pwrite, m_paddr, m_pwdata, m_pstrb);
      end
      cyc();
      penable = 1'b1;
      sample();
      n_chk++;
      if (m_psel !== 4'b0010 || m_penable !== 1'b1 || pready !== 1'b1) begin
         n_fail++;
         $display("FAIL wr_access: got psel=%b pen=%b rdy=%b", m_psel, m_penable, pready);
      end else begin
         e = sb.pop_front();
         n_chk++;
         if ({presp, prdata} !== {e.rsp, e.data}) begin
            n_fail++;
            $display("FAIL wr_resp: got %b/%h want %b/%h", presp, prdata, e.rsp, e.data);
         end
      end
      cyc();
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pstrb = '0; m_pready = '0;
      sample();
      n_chk++;
      if (m_psel !== 4'b0 || pready !== 1'b1) begin
         n_fail++;
         $display("FAIL wr_idle: got psel=%b rdy=%b", m_psel, pready);
      end
   endtask
   task automatic test_decerr();
      exp_t e;
      cyc();
      psel = 1'b1; penable = 1'b0; paddr = 32'h0000_3000;
      slv(3, 1'b1, 2'b00, 32'h0);
      push_exp(2'b11, 32'h0);
      sample();
      n_chk++;
      if (m_psel3 !== 3'b0 || pready3 !== 1'b1) begin
         n_fail++;
         $display("FAIL dec_setup: got psel=%b rdy=%b want 000/1", m_psel3, pready3);
      end
      cyc();
      penable = 1'b1;
      sample();
      n_chk++;
      if (m_psel3 !== 3'b0 || pready3 !== 1'b1) begin
         n_fail++;
         $display("FAIL dec_access: got psel=%b rdy=%b want 000/1", m_psel3, pready3);
      end
      e = sb.pop_front();
      n_chk++;
      if ({presp3, prdata3} !== {e.rsp, e.data}) begin
         n_fail++;
         $display("FAIL dec_resp: got %b/%h want %b/%h", presp3, prdata3, e.rsp, e.data);
      end
      cyc();
      psel = 1'b0; penable = 1'b0; m_pready = '0;
      sample();
      n_chk++;
      if (m_psel3 !== 3'b0 || presp3 !== 2'b00) begin
         n_fail++;
         $display("FAIL dec_idle: got psel=%b resp=%b", m_psel3, presp3);
      end
   endtask
   task automatic test_back_to_back();
      exp_t e;
      logic [31:0] addrs [2];
      addrs[0] = 32'h0000_3000;
      addrs[1] = 32'h0000_3004;
      for (int k = 0; k < 2; k++) begin
         cyc();
         psel = 1'b1; penable = 1'b0; paddr = addrs[k];
         slv(3, 1'b1, 2'b00, 32'hCAFE_0000 + 32'(k));
         push_exp(2'b00, 32'hCAFE_0000 + 32'(k));
         sample();
         n_chk++;
         if (m_psel !== 4'b1000 || m_penable !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_setup%0d: got psel=%b pen=%b want 1000/0", k, m_psel, m_penable);
         end
         cyc();
         penable = 1'b1;
         sample();
         n_chk++;
         if (m_psel !== 4'b1000 || m_penable !== 1'b1 || pready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_access%0d: got psel=%b pen=%b rdy=%b", k, m_psel, m_penable, pready);
         end
         e = sb.pop_front();
         n_chk++;
         if ({presp, prdata} !== {e.rsp, e.data}) begin
            n_fail++;
            $display("FAIL b2b_data%0d: got %b/%h want %b/%h", k, presp, prdata, e.rsp, e.data);
         end
      end
      cyc();
      psel = 1'b0; penable = 1'b0; m_pready = '0;
      sample();
      n_chk++;
      if (m_psel !== 4'b0) begin
         n_fail++;
         $display("FAIL b2b_idle: got psel=%b want 0000", m_psel);
      end
   endtask
   task automatic test_rst_mid();
      exp_t e;
      cyc();
      psel = 1'b1; penable = 1'b0; paddr = 32'h0000_1000;
      m_pready = '0;
      sample();
      cyc();
      penable = 1'b1;
      sample();
      n_chk++;
      if (m_psel !== 4'b0010 || pready !== 1'b0) begin
         n_fail++;
         $display("FAIL rm_wait: got psel=%b rdy=%b want 0010/0", m_psel, pready);
      end
      cyc();
      rst = 1'b1;
      sample();
      n_chk++;
      if (m_psel !== 4'b0) begin
         n_fail++;
         $display("FAIL rm_drop: got psel=%b want 0000", m_psel);
      end
      cyc();
      rst = 1'b0; psel = 1'b0; penable = 1'b0;
      sample();
      n_chk++;
      if (m_psel !== 4'b0 || pready !== 1'b1 || tmo_count !== 8'd0 || tmo_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL rm_after: got psel=%b rdy=%b cnt=%0d pulse=%b", m_psel, pready, tmo_count, tmo_pulse);
      end
      cyc();
      psel = 1'b1; penable = 1'b0; paddr = 32'h0000_1000;
      slv(1, 1'b1, 2'b00, 32'h5555_AAAA);
      push_exp(2'b00, 32'h5555_AAAA);
      sample();
      cyc();
      penable = 1'b1;
      sample();
      e = sb.pop_front();
      n_chk++;
      if ({m_psel, pready, presp, prdata} !== {4'b0010, 1'b1, e.rsp, e.data}) begin
         n_fail++;
         $display("FAIL rm_fresh: got psel=%b rdy=%b %b/%h want 0010/1 %b/%h", m_psel, pready, presp, prdata, e.rsp, e.data);
      end
      cyc();
      psel = 1'b0; penable = 1'b0; m_pready = '0;
      sample();
   endtask
   task automatic test_timeout();
      exp_t e;
      int bad;
      bad = 0;
      cyc();
      psel = 1'b1; penable = 1'b0; paddr = 32'h0000_0000;
      m_pready = '0;
      slv(0, 1'b0, 2'b00, 32'h0BAD_0BAD);
      push_exp(2'b10, 32'hDEAD_BEEF);
      sample();
      n_chk++;
      if (m_psel !== 4'b0001) begin
         n_fail++;
         $display("FAIL tmo_setup: got psel=%b want 0001", m_psel);
      end
      for (int k = 0; k < 255; k++) begin
         cyc();
         penable = 1'b1;
         sample();
         if (m_psel !== 4'b0001 || pready !== 1'b0 || tmo_pulse !== 1'b0) bad++;
      end
      n_chk++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL tmo_wait: %0d of 255 wait cycles wrong, want 0", bad);
      end
      cyc();
      m_pready[0] = 1'b1;
      sample();
      n_chk++;
      if (m_psel !== 4'b0 || m_penable !== 1'b0 || pready !== 1'b1 || tmo_pulse !== 1'b1) begin
         n_fail++;
         $display("FAIL tmo_abort: got psel=%b pen=%b rdy=%b pulse=%b want 0000/0/1/1", m_psel, m_penable, pready, tmo_pulse);
      end
      e = sb.pop_front();
      n_chk++;
      if ({presp, prdata} !== {e.rsp, e.data}) begin
         n_fail++;
         $display("FAIL tmo_resp: got %b/%h want %b/%h", presp, prdata, e.rsp, e.data);
      end
      cyc();
      psel = 1'b0; penable = 1'b0;
      sample();
      n_chk++;
      if (tmo_pulse !== 1'b0 || tmo_count !== 8'd1 || m_psel !== 4'b0 || pready !== 1'b1) begin
         n_fail++;
         $display("FAIL tmo_after: got pulse=%b cnt=%0d psel=%b rdy=%b want 0/1/0000/1", tmo_pulse, tmo_count, m_psel, pready);
      end
      cyc();
      m_pready = '0;
      sample();
      n_chk++;
      if (tmo_count !== 8'd1 || tmo_pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_hold: got cnt=%0d pulse=%b want 1/0", tmo_count, tmo_pulse);
      end
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end
   initial begin
      test_reset();
      test_read();
      test_write();
      test_decerr();
      test_back_to_back();
      test_rst_mid();
      test_timeout();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/apb_fanout_tmo.md
Name: apb_fanout_tmo

Overview:
- Sits directly downstream of the AXI-to-APB bridge; consumes its 32-bit APB master port.
- Decodes paddr into one of NSLV APB slave selects and muxes the selected slave's pready/presp/prdata back upstream.
- A per-transfer timeout watchdog aborts hung slaves with SLVERR, so the bridge never deadlocks.

Parameters:
- AWID, 32, address width.
- PDWID, 32, APB data width; equals half of the bridge AXI data width.
- NSLV, 4, number of slave ports (2..16).
- SEL_LO, 12, LSB of the slave-select field in paddr; field width is SELW=$clog2(NSLV).
- TMO, 255, wait cycles in ACCESS before abort (1..255).
- ERRDATA, 32'hDEAD_BEEF, prdata returned on timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_psel  in  1  upstream select
- s_penable  in  1  upstream enable
- s_pwrite  in  1  write
- s_paddr  in  AWID  address
- s_pwdata  in  PDWID  write data
- s_pstrb  in  PDWID/8  byte strobes
- s_pready  out  1  ready to bridge
- s_presp  out  2  response to bridge
- s_prdata  out  PDWID  read data to bridge
- m_psel  out  NSLV  one-hot slave selects
- m_penable  out  1  shared enable
- m_pwrite, m_paddr, m_pwdata, m_pstrb  out  1/AWID/PDWID/PDWID/8  broadcast copies of s_* (combinational pass-through)
- m_pready  in  NSLV  per-slave ready
- m_presp  in  2*NSLV  per-slave response, slave i at [2i+1:2i]
- m_prdata  in  PDWID*NSLV  per-slave read data
- tmo_pulse  out  1  one-cycle pulse per timeout abort
- tmo_count  out  8  saturating count of timeouts

Behaviour:
- States: IDLE, ACCESS, ABORT, DECERR. Registers: cur_sel[SELW], wcnt[8], tmo_count.
- Reset (rst=1 at clk edge): state=IDLE, cur_sel=0, wcnt=0, tmo_count=0, tmo_pulse=0. All outputs below follow from IDLE: m_psel=0, m_penable=0, s_pready=1, s_presp=0, s_prdata=0.
- IDLE:
  - On s_psel && !s_penable (setup), decode idx=s_paddr[SEL_LO+:SELW].
  - idx<NSLV: m_psel[idx]=1 combinationally this cycle; cur_sel<=idx; wcnt<=0; go ACCESS.
  - idx>=NSLV: m_psel=0; go DECERR.
  - s_pready=1 throughout IDLE/setup, because the bridge also waits on pready in its setup states.
- ACCESS:
  - m_psel[cur_sel]=1; m_penable=s_penable.
  - s_pready=m_pready[cur_sel]; s_presp=m_presp[cur_sel]; s_prdata=m_prdata[cur_sel].
  - On s_penable && m_pready[cur_sel]: go IDLE. A new setup is accepted in the very next cycle, so back-to-back low/high halves run with zero bubble.
  - No ready: wcnt++. When wcnt==TMO-1 with no ready: go ABORT.
  - s_psel dropped: go IDLE silently. This is a protocol violation and is not counted.
- ABORT (1 cycle):
  - m_psel=0, m_penable=0.
  - s_pready=1, s_presp=2'b10, s_prdata=ERRDATA.
  - tmo_pulse=1; tmo_count++ saturating at 255; go IDLE.
  - A late m_pready from the aborted slave is ignored.
- DECERR (access cycle):
  - m_psel=0.
  - s_pready=1, s_presp=2'b11 (DECERR), s_prdata=0; go IDLE.
- Timeout latency: abort response appears exactly TMO cycles after ACCESS entry.
- m_presp and m_prdata of unselected slaves never propagate.
- Reset mid-ACCESS drops m_psel the same cycle; no abort pulse is generated.

Decomposition:
- Package apb_fanout_pkg: state enum, RESP_OKAY/RESP_SLVERR/RESP_DECERR constants, default ERRDATA.
- One sub-module, apb_tmo_counter: wcnt with clear, enable and hit output, plus a saturating tmo_count.
- Slave mux stays inline.

Test Plan:
- Read, paddr=0x0000_2004, slave 2 ready after 3 wait cycles, prdata=0x1234_5678 -> m_psel=4'b0100 during setup and access; s_prdata=0x1234_5678 with s_presp=0 on the ready cycle; IDLE next cycle.
- Write, paddr=0x0000_1000, pwdata=0xA5A5_A5A5, pstrb=4'hF, slave 1 ready with 0 waits -> m_pwdata/m_pstrb match; m_psel=4'b0010; 2-cycle transfer.
- Slave 0 never ready, TMO=255 -> abort cycle 255 cycles after ACCESS entry with s_pready=1, s_presp=2'b10, s_prdata=0xDEAD_BEEF; tmo_pulse single cycle; tmo_count=1; late m_pready ignored.
- NSLV=3, paddr=0x0000_3000 -> m_psel=0 throughout; s_presp=2'b11 in access; s_prdata=0.
- Back-to-back low/high halves to slave 3 (addr 0x3000 then 0x3004), each 0 waits -> four consecutive psel cycles with no bubble; penable sequence 0,1,0,1.
- rst asserted during ACCESS to slave 1 -> next cycle m_psel=0, s_pready=1, tmo_count unchanged; a fresh transfer then completes normally.
